// File: rtl/ascon_word_serializer.sv
// Captures a WIDTH-bit word in one cycle and streams it out MS-word first over valid/ready.
// Optional ASCON_SER_ZEROIZE_EN: clears the shift register on completion and masks word_o while idle.
module ascon_word_serializer #(
  parameter int WIDTH  = 128,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic [WORD_W-1:0] word_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int NWORDS = WIDTH / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Every transfer shifts, so after a full block the register is empty in either build.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          shift_d = data_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          shift_d = shift_q << WORD_W;
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
`ifdef ASCON_SER_ZEROIZE_EN
            shift_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid_o = (state_q == SEND);
  assign busy_o  = (state_q == SEND);
  assign last_o  = (state_q == SEND) && (cnt_q == LAST_IDX);
  assign done_o  = done_q;

`ifdef ASCON_SER_ZEROIZE_EN
  assign word_o = valid_o ? shift_q[WIDTH-1 -: WORD_W] : '0;
`else
  assign word_o = shift_q[WIDTH-1 -: WORD_W];
`endif

endmodule

// File: doc/ascon_word_serializer.md
Name: ascon_word_serializer

Overview:
- Read-side counterpart of the ASCON enable-loaded state/tag registers.
- Captures a wide word (tag, ciphertext block or state slice) in one cycle and streams it out as narrow words over a valid/ready handshake.
- Sits between the ASCON core output registers and the subsystem's narrow readout bus.

Parameters:
- WIDTH, 128, width of the captured word in bits; must be an integer multiple of WORD_W.
- WORD_W, 32, width of each output word in bits.
- Derived, not a parameter: NWORDS = WIDTH/WORD_W, must be >= 2. Counter width is $clog2(NWORDS).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. Asynchronous assertion, active-low.
- load_i  input  1  capture request for data_i. Honoured only in IDLE.
- data_i  input  WIDTH  wide word to serialize.
- word_o  output  WORD_W  current output word.
- valid_o  output  1  word_o holds a valid word.
- ready_i  input  1  downstream accepts word_o.
- last_o  output  1  word_o is the final word of the block. Only meaningful while valid_o=1.
- busy_o  output  1  serializer is in SEND.
- done_o  output  1  one-cycle pulse after the final word transfers.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, shift register=0, counter=0.
- Outputs during reset: word_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0.
- States: IDLE and SEND.
- IDLE, load_i=1 at a clock edge:
  - Shift register <= data_i; counter <= 0; state <= SEND.
  - valid_o=1 from the next cycle, so latency from load to first word is 1 cycle.
- IDLE, load_i=0: no change; valid_o=0.
- SEND:
  - valid_o=1, busy_o=1.
  - word_o = shift register bits [WIDTH-1 -: WORD_W]. The most significant word goes out first.
- Transfer occurs on any clock edge with valid_o=1 and ready_i=1.
- On a non-final transfer:
  - Shift register shifts left by WORD_W, zeros in.
  - counter increments.
- While valid_o=1 and ready_i=0: word_o, last_o and counter hold stable. valid_o never drops before the transfer.
- last_o = (counter == NWORDS-1) while in SEND.
- On the final transfer (last_o=1):
  - state <= IDLE.
  - done_o=1 for exactly the following cycle.
  - valid_o=0 in that cycle.
- load_i while in SEND, including the final-transfer cycle, is ignored; no queueing. A new load is accepted from the cycle in which done_o=1 onward.
- ready_i is ignored while valid_o=0.
- Reset asserted mid-block aborts the block immediately:
  - Outputs return to reset values, with no done_o pulse.
  - The partially sent data is lost.
- Throughput with ready_i held at 1: NWORDS words in NWORDS consecutive cycles, then one IDLE cycle before the next load is possible.

Optional Feature:
- Macro: ASCON_SER_ZEROIZE_EN.
- Defined:
  - Shift register is cleared to 0 on the final transfer.
  - word_o is forced to 0 whenever valid_o=0, so no residual tag/key material is visible outside SEND.
- Not defined:
  - Shift register retains its shifted contents after completion.
  - word_o shows the register MS word regardless of valid_o; consumers must qualify it with valid_o.
- Handshake timing is identical in both builds.

Test Plan:
- Basic stream (WIDTH=128, WORD_W=32):
  - Stimulus: load data_i=0x00112233_44556677_8899AABB_CCDDEEFF with ready_i=1.
  - Response: word_o = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles starting 1 cycle after load; last_o=1 only on 0xCCDDEEFF; done_o pulses the following cycle.
- Backpressure:
  - Stimulus: same data; ready_i=0 for 3 cycles while the second word is presented.
  - Response: word_o holds 0x44556677, valid_o stays 1, counter is unchanged; the stream resumes in order once ready_i=1; total words = 4.
- Load while busy:
  - Stimulus: during SEND, pulse load_i with 0xFFFF…FFFF.
  - Response: ignored; the original four words are completed unchanged. A load in the done_o cycle is accepted, and its first word appears the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 after the second transfer, asynchronously between edges.
  - Response: valid_o, busy_o and word_o drop to 0 immediately; no done_o; after release the block is IDLE and accepts a new load.
- Zeroize build (ASCON_SER_ZEROIZE_EN defined):
  - Stimulus: after the basic stream completes, observe outputs.
  - Response: word_o=0 and the shift register is 0 while idle. Non-zeroize build: word_o shows residual shifted data (0 after a full shift) with valid_o=0.
- Parameter sweep:
  - Stimulus: WIDTH=320, WORD_W=64, with ready_i toggled randomly.
  - Response: exactly 5 transfers, MS-word first, last_o only on the 5th, data matches the loaded word.
